fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding request FSM with branch-tag squash and output hold register.
// Optional FETCH_PERF_CNT_EN adds fetch_count/squash_count performance counter outputs.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  sel_pc,
  input  logic [31:0] branch_target,
  input  logic        branch_ref_global,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        branch_out,
  output logic        valid_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [15:0] squash_count
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [31:0] NOP_WORD = 32'hF000_0000;

  logic [1:0]  state;
  logic [31:0] pc;
  logic        tag;
  logic        drop;
  logic [31:0] hold_word;

  logic redirect;
  logic resp_ok;
  logic out_free;
  logic load_mem;
  logic load_hold;
  logic to_hold;
  logic squash_resp;
  logic squash_hold;
  logic deliver;

  always_comb begin
    redirect    = (sel_pc == 2'b11);
    resp_ok     = (state == WAIT) && imem_valid && !drop && (tag == branch_ref_global);
    out_free    = !valid_out || !stall;
    load_mem    = !redirect && resp_ok && out_free;
    to_hold     = !redirect && resp_ok && !out_free;
    load_hold   = !redirect && (state == HOLD) && !stall;
    squash_resp = (state == WAIT) && imem_valid && (redirect || !resp_ok);
    squash_hold = redirect && (state == HOLD);
    deliver     = load_mem || load_hold;
  end

  // A request is withheld on a redirect cycle so that no orphan response can
  // later be mistaken for the fetch of the new target.
  assign imem_req  = (state == ISSUE) && !redirect;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= '0;
      tag        <= 1'b0;
      drop       <= 1'b0;
      hold_word  <= '0;
      instr_out  <= NOP_WORD;
      pc_out     <= '0;
      branch_out <= 1'b0;
      valid_out  <= 1'b0;
    end else begin
      if (redirect) begin
        state <= ((state == WAIT) && !imem_valid) ? WAIT : ISSUE;
      end else begin
        case (state)
          IDLE:    state <= ISSUE;
          ISSUE:   state <= WAIT;
          WAIT:    if (imem_valid) state <= to_hold ? HOLD : ISSUE;
          HOLD:    if (!stall) state <= ISSUE;
          default: state <= IDLE;
        endcase
      end

      if (redirect) pc <= branch_target;
      else if (deliver) pc <= pc + 32'd4;

      if ((state == ISSUE) && !redirect) tag <= branch_ref_global;

      // A redirect during WAIT marks the in-flight response for discard.
      drop <= (state == WAIT) && !imem_valid && (drop || redirect);

      if (to_hold) hold_word <= imem_rdata;

      if (deliver) begin
        instr_out  <= load_hold ? hold_word : imem_rdata;
        pc_out     <= pc;
        branch_out <= tag;
        valid_out  <= 1'b1;
      end else if (redirect || !stall) begin
        instr_out <= NOP_WORD;
        valid_out <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count  <= '0;
      squash_count <= '0;
    end else begin
      if (deliver) fetch_count <= fetch_count + 32'd1;
      if ((squash_resp || squash_hold) && (squash_count != 16'hFFFF))
        squash_count <= squash_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory/redirect model predicts delivered words,
// a separate monitor pops them as the DUT presents them on the output register.
module tb_fetch_unit;
  localparam logic [31:0] NOP_WORD = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  sel_pc;
  logic [31:0] branch_target;
  logic        branch_ref_global;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        branch_out;
  logic        valid_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [15:0] squash_count;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .sel_pc            (sel_pc),
    .branch_target     (branch_target),
    .branch_ref_global (branch_ref_global),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_valid        (imem_valid),
    .imem_rdata        (imem_rdata),
    .instr_out         (instr_out),
    .pc_out            (pc_out),
    .branch_out        (branch_out),
    .valid_out         (valid_out)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count       (fetch_count),
    .squash_count      (squash_count)
`endif
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        tag;
  } item_t;

  item_t       expq[$];
  int          errors = 0;
  int          checks = 0;
  int          presented = 0;

  // Memory-side and program-counter model
  bit          outstanding = 0;
  bit          out_killed = 0;
  logic [31:0] out_addr = '0;
  logic [31:0] out_data = '0;
  logic        out_tag = 1'b0;
  int          lat_cnt = 0;
  logic [31:0] exp_pc = '0;
  int          squash_exp = 0;
  int          idle_cycles = 0;
  bit          fixed_word = 0;
  int          fixed_lat = 0;
  logic [31:0] last_req_addr = '0;
  bit          wrap_seen = 0;

  function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void check1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  // Monitor: compares each newly presented word against the scoreboard head.
  initial begin
    bit    pv;
    item_t it;
    item_t cur;
    pv  = 0;
    cur = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check1("rst_valid_out", valid_out, 1'b0);
        check32("rst_instr_out", instr_out, NOP_WORD);
        check32("rst_pc_out", pc_out, 32'h0);
        check1("rst_branch_out", branch_out, 1'b0);
        check1("rst_imem_req", imem_req, 1'b0);
        check32("rst_imem_addr", imem_addr, 32'h0);
        pv = 0;
        presented = 0;
      end else begin
        if (valid_out && (!pv || !stall)) begin
          if (expq.size() == 0) begin
            check1("spurious_valid_out", valid_out, 1'b0);
          end else begin
            it = expq.pop_front();
            check32("instr_out", instr_out, it.data);
            check32("pc_out", pc_out, it.addr);
            check1("branch_out", branch_out, it.tag);
            cur = it;
            presented++;
          end
        end else if (valid_out) begin
          check32("held_instr_out", instr_out, cur.data);
          check32("held_pc_out", pc_out, cur.addr);
          check1("held_branch_out", branch_out, cur.tag);
        end else begin
          check32("empty_instr_out", instr_out, NOP_WORD);
        end
`ifdef FETCH_PERF_CNT_EN
        check32("fetch_count", fetch_count, presented);
        check32("squash_count", {16'h0, squash_count}, (squash_exp > 65535) ? 65535 : squash_exp);
`endif
        pv = valid_out;
      end
    end
  end

  // One cycle of stimulus plus model update for the coming clock edge.
  task automatic step(input bit s, input bit redir, input logic [31:0] tgt, input bit tog);
    bit resp;
    @(negedge clk);
    stall         = s;
    sel_pc        = redir ? 2'b11 : 2'($urandom_range(0, 2));
    branch_target = redir ? tgt : $urandom();
    if (tog) branch_ref_global = ~branch_ref_global;
    resp       = 0;
    imem_valid = 1'b0;
    imem_rdata = $urandom();
    if (outstanding) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        resp        = 1;
        imem_valid  = 1'b1;
        imem_rdata  = out_data;
        outstanding = 0;
      end
    end
    if (resp) begin
      if (!redir && !out_killed && (out_tag == branch_ref_global)) begin
        expq.push_back('{addr: out_addr, data: out_data, tag: out_tag});
        exp_pc = out_addr + 32'd4;
      end else begin
        squash_exp++;
      end
    end
    if (redir) begin
      squash_exp += expq.size();
      expq.delete();
      exp_pc = tgt;
      if (outstanding) out_killed = 1;
    end
    #1;
    if (redir) check1("req_on_redirect", imem_req, 1'b0);
    if (imem_req === 1'b1) begin
      check32("imem_addr", imem_addr, exp_pc);
      check1("single_outstanding", outstanding, 1'b0);
      check32("req_with_word_pending", expq.size(), 0);
      if (last_req_addr == 32'hFFFF_FFFC && imem_addr == 32'h0) wrap_seen = 1;
      last_req_addr = imem_addr;
      outstanding   = 1;
      out_killed    = 0;
      out_addr      = imem_addr;
      out_tag       = branch_ref_global;
      out_data      = fixed_word ? 32'hE280_1001 : $urandom();
      lat_cnt       = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 3);
      idle_cycles   = 0;
    end else begin
      idle_cycles++;
      if (idle_cycles > 40) begin
        check32("req_timeout_cycles", idle_cycles, 0);
        idle_cycles = 0;
      end
    end
  endtask

  task automatic do_reset(input bit stray);
    @(negedge clk);
    rst         = 1'b1;
    stall       = 1'b0;
    sel_pc      = 2'b00;
    imem_valid  = 1'b0;
    outstanding = 0;
    out_killed  = 0;
    expq.delete();
    exp_pc      = '0;
    squash_exp  = 0;
    idle_cycles = 0;
    repeat (2) @(negedge clk);
    if (stray) begin
      imem_valid = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_until_outstanding();
    for (int i = 0; i < 30 && !outstanding; i++) step(0, 0, '0, 0);
    check1("reached_wait", outstanding, 1'b1);
  endtask

  initial begin
    rst               = 1'b1;
    stall             = 1'b0;
    sel_pc            = 2'b00;
    branch_target     = '0;
    branch_ref_global = 1'b0;
    imem_valid        = 1'b0;
    imem_rdata        = '0;
    do_reset(0);

    // Fixed word, two-cycle memory latency: addresses 0,4,8,...
    fixed_word = 1;
    fixed_lat  = 2;
    for (int i = 0; i < 12; i++) step(0, 0, '0, 0);

    // Long stall so a second word lands in the holding register.
    for (int i = 0; i < 15; i++) step(1, 0, '0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, '0, 0);

    // Redirect while a response is in flight, with the reference bit toggling.
    run_until_outstanding();
    step(0, 1, 32'h0000_0100, 1);
    for (int i = 0; i < 10; i++) step(0, 0, '0, 0);

    // PC wrap from the top of the address space.
    step(0, 1, 32'hFFFF_FFFC, 0);
    for (int i = 0; i < 10; i++) step(0, 0, '0, 0);
    check1("pc_wrap_seen", wrap_seen, 1'b1);

    // Reset mid-WAIT followed by a stray response.
    run_until_outstanding();
    do_reset(1);
    for (int i = 0; i < 10; i++) step(0, 0, '0, 0);

    fixed_word = 0;
    fixed_lat  = 0;
    for (int i = 0; i < 1500; i++) begin
      int  p_stall;
      bit  redir;
      logic [31:0] tgt;
      p_stall = (i < 500) ? 10 : ((i < 1000) ? 40 : 70);
      redir   = ($urandom_range(0, 99) < 6);
      tgt     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      step($urandom_range(0, 99) < p_stall, redir, tgt, $urandom_range(0, 99) < 5);
    end

    for (int i = 0; i < 40; i++) step(0, 0, '0, 0);
    @(posedge clk);
    #2;
    check32("drain_queue_empty", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation reached %0t without finishing", $time);
    $fatal(1, "timeout");
  end

endmodule
